// File: rtl/led_pattern_if.sv
// Configuration write port of led_pattern: one-cycle register writes, no handshake.
// The driver uses the master modport; the pattern generator uses the slave modport.
interface led_pattern_if #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [1:0]      cfg_sel;
  logic [CNT_W-1:0] cfg_data;

  modport master (output cfg_we, cfg_ch, cfg_sel, cfg_data);
  modport slave  (input  cfg_we, cfg_ch, cfg_sel, cfg_data);
endinterface

// File: rtl/led_pattern.sv
// Multi-channel LED pattern generator: off / on / blink / PWM breathe per channel,
// advanced by a shared tick strobe and reprogrammed through led_pattern_if.

module led_pattern_ch #(
  parameter int CNT_W      = 8,
  parameter int PWM_W      = 8,
  parameter int DEF_PERIOD = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             sync_i,
  input  logic             wr_mode_i,
  input  logic             wr_period_i,
  input  logic             wr_duty_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  output logic             led_o
);
  typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BREATHE} mode_e;

  localparam logic [PWM_W-1:0] LVL_TOP = {{(PWM_W-1){1'b1}}, 1'b0};
  localparam logic [PWM_W-1:0] LVL_ONE = {{(PWM_W-1){1'b0}}, 1'b1};

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] level_q, level_d;
  logic             dir_q, dir_d;
  logic             led_q, led_d;

  logic [CNT_W-1:0] last_cnt;
  logic             wrap;

  // A zero period behaves as one tick, so the last count is simply period-1 floored at 0.
  assign last_cnt = (period_q == '0) ? '0 : period_q - 1'b1;
  assign wrap     = (cnt_q >= last_cnt);

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    dir_d    = dir_q;

    if (tick_i && (mode_q == M_BLINK || mode_q == M_BREATHE)) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (wrap && mode_q == M_BREATHE) begin
        if (!dir_q) begin
          level_d = level_q + 1'b1;
          if (level_q == LVL_TOP) dir_d = 1'b1;
        end else begin
          level_d = level_q - 1'b1;
          if (level_q == LVL_ONE) dir_d = 1'b0;
        end
      end
    end

    // A period write cancels the whole tick advance, including any breathe step.
    if (wr_period_i) begin
      period_d = wdata_i;
      cnt_d    = '0;
      level_d  = level_q;
      dir_d    = dir_q;
    end
    if (wr_mode_i) begin
      mode_d  = mode_e'(wdata_i[1:0]);
      cnt_d   = '0;
      level_d = '0;
      dir_d   = 1'b0;
    end
    if (wr_duty_i) duty_d = wdata_i;

    if (sync_i) begin
      cnt_d   = '0;
      level_d = '0;
      dir_d   = 1'b0;
    end
  end

  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      M_OFF:     led_d = 1'b0;
      M_ON:      led_d = 1'b1;
      M_BLINK:   led_d = (cnt_q < duty_q);
      M_BREATHE: led_d = (pwm_cnt_i < level_q);
      default:   led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= M_BLINK;
      period_q <= CNT_W'(DEF_PERIOD);
      duty_q   <= CNT_W'(DEF_PERIOD / 2);
      cnt_q    <= '0;
      level_q  <= '0;
      dir_q    <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      dir_q    <= dir_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;
endmodule

module led_pattern #(
  parameter int N_CH       = 3,
  parameter int CNT_W      = 8,
  parameter int PWM_W      = 8,
  parameter int DEF_PERIOD = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            sync,
  led_pattern_if.slave    cfg,
  output logic [N_CH-1:0] led
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [N_CH-1:0]  wr_hit, wr_mode, wr_period, wr_duty;

  assign pwm_cnt_d = sync ? '0 : pwm_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end

  // Out-of-range channel numbers match no lane; select 3 matches no field.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_hit[i]    = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));
    assign wr_mode[i]   = wr_hit[i] && (cfg.cfg_sel == 2'd0);
    assign wr_period[i] = wr_hit[i] && (cfg.cfg_sel == 2'd1);
    assign wr_duty[i]   = wr_hit[i] && (cfg.cfg_sel == 2'd2);

    led_pattern_ch #(
      .CNT_W      (CNT_W),
      .PWM_W      (PWM_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .sync_i      (sync),
      .wr_mode_i   (wr_mode[i]),
      .wr_period_i (wr_period[i]),
      .wr_duty_i   (wr_duty[i]),
      .wdata_i     (cfg.cfg_data),
      .pwm_cnt_i   (pwm_cnt_q),
      .led_o       (led[i])
    );
  end
endmodule

// File: tb/tb_led_pattern.sv
// Self-checking bench for led_pattern: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a behavioural model.
module tb_led_pattern;
  localparam int N_CH       = 3;
  localparam int CNT_W      = 8;
  localparam int PWM_W      = 3;
  localparam int DEF_PERIOD = 10;
  localparam int M          = (1 << PWM_W) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            tick;
  logic            sync;
  logic [N_CH-1:0] led;

  led_pattern_if #(.N_CH(N_CH), .CNT_W(CNT_W)) cfg ();

  led_pattern #(
    .N_CH(N_CH), .CNT_W(CNT_W), .PWM_W(PWM_W), .DEF_PERIOD(DEF_PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .sync(sync), .cfg(cfg), .led(led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel tracks ticks counted since its counter was last cleared
  // and breathe wraps since its level was last cleared; outputs follow by arithmetic.
  int m_mode[N_CH], m_per[N_CH], m_duty[N_CH], m_ph[N_CH], m_wr[N_CH];
  int m_pwm;
  logic [N_CH-1:0] exp_led;

  function automatic int pe(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic int tri_level(input int w);
    int t;
    t = w % (2 * M);
    return (t <= M) ? t : 2 * M - t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        m_mode[c] <= 2;
        m_per[c]  <= DEF_PERIOD;
        m_duty[c] <= DEF_PERIOD / 2;
        m_ph[c]   <= 0;
        m_wr[c]   <= 0;
      end
      m_pwm   <= 0;
      exp_led <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        automatic int p   = pe(m_per[c]);
        automatic int ph  = m_ph[c];
        automatic int wr  = m_wr[c];
        automatic bit hit = cfg.cfg_we && (int'(cfg.cfg_ch) == c) && (cfg.cfg_sel != 2'd3);
        automatic bit clr_c = sync || (hit && cfg.cfg_sel <= 2'd1);
        automatic bit clr_l = sync || (hit && cfg.cfg_sel == 2'd0);
        case (m_mode[c])
          0:       exp_led[c] <= 1'b0;
          1:       exp_led[c] <= 1'b1;
          2:       exp_led[c] <= ((ph % p) < m_duty[c]);
          default: exp_led[c] <= (m_pwm < tri_level(wr));
        endcase
        if (tick && m_mode[c] >= 2 && !clr_c) begin
          ph++;
          if (m_mode[c] == 3 && (ph % p) == 0) wr++;
        end
        if (clr_c) ph = 0;
        if (clr_l) wr = 0;
        m_ph[c] <= ph;
        m_wr[c] <= wr;
        if (hit) begin
          case (cfg.cfg_sel)
            2'd0:    m_mode[c] <= int'(cfg.cfg_data) % 4;
            2'd1:    m_per[c]  <= int'(cfg.cfg_data);
            default: m_duty[c] <= int'(cfg.cfg_data);
          endcase
        end
      end
      m_pwm <= sync ? 0 : (m_pwm + 1) % (M + 1);
    end
  end

  always @(negedge clk) chk("model_led", int'(led), int'(exp_led));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    cfg.cfg_we   = 1'b1;
    cfg.cfg_ch   = 2'(ch);
    cfg.cfg_sel  = 2'(sel);
    cfg.cfg_data = 8'(data);
    cyc();
    cfg.cfg_we   = 1'b0;
  endtask

  task automatic tk();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  int lv[19] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5};

  initial begin
    int hi;
    rst = 1'b1; tick = 1'b0; sync = 1'b0;
    cfg.cfg_we = 1'b0; cfg.cfg_ch = '0; cfg.cfg_sel = '0; cfg.cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", int'(led), 0);
    rst = 1'b0;
    cyc();
    chk("first_led", int'(led), 7);

    // Default blink: 5 on, 5 off, all channels in phase.
    for (int k = 1; k <= 40; k++) begin
      tk();
      chk("default_blink", int'(led), ((k % 10) < 5) ? 7 : 0);
    end

    wr(1, 1, 4);
    wr(1, 2, 1);
    for (int k = 1; k <= 12; k++) begin
      tk();
      chk("ch1_p4_d1", int'(led[1]), int'((k % 4) == 0));
      chk("ch0_undisturbed", int'(led[0]), int'((k % 10) < 5));
    end

    wr(2, 2, 0);
    for (int k = 0; k < 3; k++) begin tk(); chk("duty0_off", int'(led[2]), 0); end
    wr(2, 2, 255);
    for (int k = 0; k < 3; k++) begin tk(); chk("duty_max_on", int'(led[2]), 1); end
    wr(2, 1, 0);
    wr(2, 2, 1);
    for (int k = 0; k < 3; k++) begin tk(); chk("period0_on", int'(led[2]), 1); end

    // Breathe with one step per tick; on-time in any 8-clk window equals the level.
    wr(0, 0, 3);
    wr(0, 1, 1);
    for (int k = 0; k < 19; k++) begin
      tk();
      hi = 0;
      repeat (8) begin
        @(negedge clk);
        hi += int'(led[0]);
      end
      chk("breathe_level", hi, lv[k]);
    end

    #2 rst = 1'b1;
    #1 chk("async_rst_led", int'(led), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    chk("post_rst_led", int'(led), 7);
    for (int k = 1; k <= 10; k++) begin
      tk();
      chk("resume_blink", int'(led[0]), int'((k % 10) < 5));
    end

    // Tick, sync and a period write in the same cycle.
    repeat (7) tk();
    chk("pre_sync_led", int'(led), 0);
    tick = 1'b1; sync = 1'b1;
    cfg.cfg_we = 1'b1; cfg.cfg_ch = 2'd0; cfg.cfg_sel = 2'd1; cfg.cfg_data = 8'd6;
    cyc();
    tick = 1'b0; sync = 1'b0; cfg.cfg_we = 1'b0;
    cyc();
    chk("sync_clear", int'(led), 7);
    for (int k = 1; k <= 6; k++) begin
      tk();
      chk("sync_ch0_p6", int'(led[0]), int'((k % 6) < 5));
      chk("sync_ch1_p10", int'(led[1]), int'((k % 10) < 5));
    end
    wr(3, 0, 0);
    wr(0, 3, 0);
    tk();
    chk("ignored_writes", int'(led), 1);

    // Randomized traffic, checked only by the model.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        tick = 1'b0; sync = 1'b0; cfg.cfg_we = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
      tick = ($urandom_range(2) == 0);
      sync = ($urandom_range(49) == 0);
      cfg.cfg_we  = ($urandom_range(3) == 0);
      cfg.cfg_ch  = 2'($urandom_range(3));
      cfg.cfg_sel = 2'($urandom_range(3));
      case (cfg.cfg_sel)
        2'd0:    cfg.cfg_data = 8'($urandom_range(3));
        2'd1:    cfg.cfg_data = 8'($urandom_range(7));
        default: cfg.cfg_data = ($urandom_range(9) == 0) ? 8'd255 : 8'($urandom_range(9));
      endcase
      cyc();
    end
    tick = 1'b0; sync = 1'b0; cfg.cfg_we = 1'b0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
